uart_rx_fifo: RTL



---
 rtl/uart_rx_fifo.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format and a first-word-fall-through
// receive FIFO carrying per-word framing and parity error flags.
module uart_rx_fifo #(
  parameter int CLK_PER_BIT = 2604,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          RX,
  input  logic                          rd_en,
  input  logic                          clr_ovr,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          frm_err,
  output logic                          par_err,
  output logic                          rdy,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF = CW'(CLK_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLK_PER_BIT - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 frm;
    logic                 par;
  } entry_t;

  logic [2:0]           sync;
  logic                 s2, fall;
  logic [2:0]           state;
  logic [CW-1:0]        baud;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 ferr, perr;
  logic                 tick, last_stop, push;

  // Synchroniser as a shift register; idles high so reset cannot fake an edge.
  always_ff @(posedge clk) begin
    if (rst) sync <= 3'b111;
    else     sync <= {sync[1:0], RX};
  end

  assign s2        = sync[1];
  assign fall      = ~sync[1] & sync[2];
  assign tick      = (baud == '0);
  assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
  assign push      = (state == STOP) && tick && last_stop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud     <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      ferr     <= 1'b0;
      perr     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (fall) begin
          baud  <= HALF;
          state <= START;
        end
        START: if (tick) begin
          if (s2) state <= IDLE;
          else begin
            baud    <= FULL;
            bit_cnt <= '0;
            state   <= DATA;
          end
        end else baud <= baud - 1'b1;
        DATA: if (tick) begin
          shreg   <= {s2, shreg[DATA_BITS-1:1]};
          baud    <= FULL;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == 4'(DATA_BITS - 1)) begin
            ferr     <= 1'b0;
            perr     <= 1'b0;
            stop_cnt <= 1'b0;
            state    <= (PARITY != 0) ? PAR : STOP;
          end
        end else baud <= baud - 1'b1;
        PAR: if (tick) begin
          perr  <= (PARITY == 2) ? ~(^shreg ^ s2) : (^shreg ^ s2);
          baud  <= FULL;
          state <= STOP;
        end else baud <= baud - 1'b1;
        STOP: if (tick) begin
          if (!s2) ferr <= 1'b1;
          // Back to IDLE mid stop bit so a following start edge is never missed.
          if (last_stop) state <= IDLE;
          else begin
            stop_cnt <= 1'b1;
            baud     <= FULL;
          end
        end else baud <= baud - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

  // Receive FIFO
  entry_t        mem [FIFO_DEPTH];
  entry_t        head, wr_entry;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, pop, wr, drop;

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign pop      = rd_en & ~empty;
  assign wr       = push & (~full | pop);
  assign drop     = push & full & ~pop;
  assign wr_entry = '{data: shreg, frm: ferr | ~s2, par: perr};

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)         overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;
    end
  end

  // Head is gated so unwritten storage never reaches the outputs.
  assign head    = mem[rd_ptr];
  assign rdy     = ~empty;
  assign rx_data = rdy ? head.data : '0;
  assign frm_err = rdy & head.frm;
  assign par_err = rdy & head.par;

endmodule
